// File: rtl/i2c_frame_pkg.sv
// Shared types and defaults for the I2C frame writer.
package i2c_frame_pkg;

  localparam int DEF_NUM_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

endpackage

// File: rtl/i2c_frame_writer_if.sv
// Bus between the frame writer, its slow clock generator and the SDA/SCL pads.
interface i2c_frame_writer_if
  import i2c_frame_pkg::*;
#(
  parameter int NUM_BYTES = DEF_NUM_BYTES
) ();

  logic                   scl_level;
  logic                   mid_high;
  logic                   mid_low;
  logic                   start_xfer;
  logic [8*NUM_BYTES-1:0] xfer_data;
  logic                   sdat_in;
  logic                   clk_enable;
  logic                   i2c_sclk;
  logic                   sdat_out;
  logic                   sdat_oe;
  logic                   busy;
  logic                   done;
  logic                   ack_error;

  modport master (
    input  scl_level, mid_high, mid_low, start_xfer, xfer_data, sdat_in,
    output clk_enable, i2c_sclk, sdat_out, sdat_oe, busy, done, ack_error
  );

  modport slave (
    output scl_level, mid_high, mid_low, start_xfer, xfer_data, sdat_in,
    input  clk_enable, i2c_sclk, sdat_out, sdat_oe, busy, done, ack_error
  );

endinterface

// File: rtl/i2c_frame_writer.sv
// Write-only I2C frame sender: start, NUM_BYTES bytes each followed by an ACK slot, stop.
//
// state | meaning
// IDLE  | bus released, SCL high, waiting for start_xfer
// START | waiting mid_high to pull SDA low (start condition)
// BIT   | shifting data bits out on mid_low
// ACK   | SDA released, sampling slave ACK on mid_high
// STOP  | three-step stop: SDA low, SCL gate off, SDA release
// DONE  | single-cycle completion pulse
module i2c_frame_writer
  import i2c_frame_pkg::*;
#(
  parameter int NUM_BYTES = DEF_NUM_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_frame_writer_if.master    bus
);

  localparam int SW = 8 * NUM_BYTES;
  localparam int BW = $clog2(NUM_BYTES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

  state_t          state, state_nx;
  logic [SW-1:0]   shift_q;
  logic [2:0]      bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic            byte_sent;
  logic [1:0]      stop_step;
  logic            scl_gate;
  logic            sda_q;
  logic            sda_oe_q;
  logic            ack_err_q;
  logic            ml, mh;
  logic            busy_c, done_c, sclk_c;

  // mid_low wins when both strobes land in the same cycle
  assign ml = bus.mid_low;
  assign mh = bus.mid_high & ~bus.mid_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start_xfer) state_nx = START;
      START:   if (mh) state_nx = BIT;
      BIT:     if (ml && byte_sent) state_nx = ACK;
      ACK:     if (mh) state_nx = (byte_cnt == LAST_BYTE) ? STOP : BIT;
      STOP:    if (ml && stop_step == 2'd2) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
    done_c = (state == DONE);
    sclk_c = scl_gate ? bus.scl_level : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_sent <= 1'b0;
      stop_step <= 2'd0;
      scl_gate  <= 1'b0;
      sda_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_xfer) begin
          shift_q   <= bus.xfer_data;
          bit_cnt   <= '0;
          byte_cnt  <= '0;
          byte_sent <= 1'b0;
          stop_step <= 2'd0;
          ack_err_q <= 1'b0;
        end
        START: if (mh) begin
          sda_q    <= 1'b0;
          sda_oe_q <= 1'b1;
          scl_gate <= 1'b1;
        end
        BIT: if (ml) begin
          // byte_sent marks the bit counter wrap so the ninth mid_low opens the ACK slot
          if (byte_sent) begin
            sda_oe_q  <= 1'b0;
            byte_sent <= 1'b0;
          end else begin
            sda_q     <= shift_q[SW-1];
            sda_oe_q  <= 1'b1;
            shift_q   <= {shift_q[SW-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 3'd1;
            byte_sent <= (bit_cnt == 3'd7);
          end
        end
        ACK: if (mh) begin
          if (bus.sdat_in) ack_err_q <= 1'b1;
          byte_cnt <= byte_cnt + BW'(1);
        end
        STOP: begin
          if (stop_step == 2'd0 && ml) begin
            sda_q     <= 1'b0;
            sda_oe_q  <= 1'b1;
            stop_step <= 2'd1;
          end else if (stop_step == 2'd1 && mh) begin
            scl_gate  <= 1'b0;
            stop_step <= 2'd2;
          end else if (stop_step == 2'd2 && ml) begin
            sda_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            stop_step <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.clk_enable = busy_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.i2c_sclk   = sclk_c;
  assign bus.sdat_out   = sda_q;
  assign bus.sdat_oe    = sda_oe_q;
  assign bus.ack_error  = ack_err_q;

endmodule

// File: tb/tb_i2c_frame_writer.sv
// Directed bench for i2c_frame_writer with a behavioural slow clock and an open-drain slave model.
module tb_i2c_frame_writer;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  i2c_frame_writer_if #(.NUM_BYTES(3)) bus ();
  i2c_frame_writer #(.NUM_BYTES(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // slow clock: period 8 clk, high for counts 0-3, mid_high at 2, mid_low at 6
  int gen_cnt   = 0;
  int ml_num    = 0;
  int inject_ml = -1;
  always @(posedge clk) begin
    #1;
    if (bus.clk_enable !== 1'b1) begin
      gen_cnt       = 0;
      ml_num        = 0;
      bus.scl_level = 1'b1;
      bus.mid_high  = 1'b0;
      bus.mid_low   = 1'b0;
    end else begin
      gen_cnt       = (gen_cnt + 1) % 8;
      bus.scl_level = (gen_cnt < 4);
      bus.mid_low   = (gen_cnt == 6);
      bus.mid_high  = (gen_cnt == 2) || (gen_cnt == 6 && ml_num == inject_ml);
      if (gen_cnt == 6) ml_num++;
    end
  end

  // line monitor and slave: decodes start/stop/bytes, pulls SDA low in ACK slots
  logic [7:0] rx [16];
  logic [7:0] cur;
  int   n_rx, n_start, n_stop, n_done, n_nack, nack_byte, mon_bit;
  int   mon_epoch = 0, seen_epoch = -1, nack_idx = -1;
  logic in_frame, slave_pull, prev_scl = 1'b1, prev_sda = 1'b1, scl_s, sda_s;
  always @(negedge clk) begin
    if (mon_epoch != seen_epoch) begin
      seen_epoch = mon_epoch;
      n_rx = 0; n_start = 0; n_stop = 0; n_done = 0; n_nack = 0; nack_byte = -1;
      mon_bit = 0; in_frame = 1'b0; slave_pull = 1'b0; cur = 8'h00;
    end
    scl_s = bus.i2c_sclk;
    sda_s = !((bus.sdat_oe && !bus.sdat_out) || slave_pull);
    if (scl_s && prev_scl && prev_sda && !sda_s) begin
      n_start++; in_frame = 1'b1; mon_bit = 0;
    end else if (scl_s && prev_scl && !prev_sda && sda_s) begin
      n_stop++; in_frame = 1'b0;
    end
    if (in_frame && scl_s && !prev_scl) begin
      if (mon_bit < 8) begin
        cur = {cur[6:0], sda_s};
        mon_bit++;
        if (mon_bit == 8) begin
          if (n_rx < 16) rx[n_rx[3:0]] = cur;
          n_rx++;
        end
      end else begin
        if (sda_s) begin n_nack++; nack_byte = n_rx - 1; end
        mon_bit = 0;
      end
    end
    if (in_frame && !scl_s && prev_scl)
      slave_pull = (mon_bit == 8) && ((n_rx - 1) != nack_idx);
    if (bus.done === 1'b1) n_done++;
    prev_scl = scl_s;
    prev_sda = sda_s;
    bus.sdat_in = !((bus.sdat_oe && !bus.sdat_out) || slave_pull);
  end

  task automatic do_frame(input logic [23:0] d, input int ign_at, input logic [23:0] d2,
                          output bit timed_out);
    bit ended = 1'b0;
    mon_epoch++;
    @(negedge clk);
    @(posedge clk); #1 bus.start_xfer = 1'b1; bus.xfer_data = d;
    @(posedge clk); #1 bus.start_xfer = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c == ign_at) begin bus.start_xfer = 1'b1; bus.xfer_data = d2; end
      else bus.start_xfer = 1'b0;
      if (bus.busy === 1'b0) begin ended = 1'b1; break; end
    end
    bus.start_xfer = 1'b0;
    @(negedge clk);
    timed_out = !ended;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start_xfer = 1'b0; bus.xfer_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.i2c_sclk !== 1'b1)   $display("FAIL reset_sclk got %b want 1", bus.i2c_sclk);     else n_pass++;
    n_checks++; if (bus.sdat_oe !== 1'b0)    $display("FAIL reset_oe got %b want 0", bus.sdat_oe);        else n_pass++;
    n_checks++; if (bus.sdat_out !== 1'b1)   $display("FAIL reset_sda got %b want 1", bus.sdat_out);      else n_pass++;
    n_checks++; if (bus.clk_enable !== 1'b0) $display("FAIL reset_clken got %b want 0", bus.clk_enable); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)       $display("FAIL reset_busy got %b want 0", bus.busy);         else n_pass++;
    n_checks++; if (bus.done !== 1'b0)       $display("FAIL reset_done got %b want 0", bus.done);         else n_pass++;
    n_checks++; if (bus.ack_error !== 1'b0)  $display("FAIL reset_ackerr got %b want 0", bus.ack_error);  else n_pass++;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_no_start busy got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_basic_frame();
    logic [23:0] d = 24'h340E4A;
    logic [7:0]  exp;
    bit to;
    do_frame(d, -1, 24'h0, to);
    n_checks++; if (to) $display("FAIL basic_timeout got timeout want done"); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp = d[23-8*i -: 8];
      n_checks++; if (rx[i] !== exp) $display("FAIL basic_byte%0d got %h want %h", i, rx[i], exp); else n_pass++;
    end
    n_checks++; if (n_rx !== 3)    $display("FAIL basic_nbytes got %0d want 3", n_rx);   else n_pass++;
    n_checks++; if (n_start !== 1) $display("FAIL basic_start got %0d want 1", n_start); else n_pass++;
    n_checks++; if (n_stop !== 1)  $display("FAIL basic_stop got %0d want 1", n_stop);   else n_pass++;
    n_checks++; if (n_done !== 1)  $display("FAIL basic_done got %0d want 1", n_done);   else n_pass++;
    n_checks++; if (n_nack !== 0)  $display("FAIL basic_nacks got %0d want 0", n_nack);  else n_pass++;
    n_checks++; if (bus.ack_error !== 1'b0) $display("FAIL basic_ackerr got %b want 0", bus.ack_error); else n_pass++;
  endtask

  task automatic test_nack();
    logic [23:0] d = 24'hC1_7F_02;
    logic [7:0]  exp;
    bit to;
    bit ended = 1'b0;
    nack_idx = 1;
    do_frame(d, -1, 24'h0, to);
    n_checks++; if (to) $display("FAIL nack_timeout got timeout want done"); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp = d[23-8*i -: 8];
      n_checks++; if (rx[i] !== exp) $display("FAIL nack_byte%0d got %h want %h", i, rx[i], exp); else n_pass++;
    end
    n_checks++; if (nack_byte !== 1) $display("FAIL nack_slot got %0d want 1", nack_byte); else n_pass++;
    n_checks++; if (bus.ack_error !== 1'b1) $display("FAIL nack_ackerr got %b want 1", bus.ack_error); else n_pass++;
    n_checks++; if (n_stop !== 1) $display("FAIL nack_stop got %0d want 1", n_stop); else n_pass++;
    n_checks++; if (n_done !== 1) $display("FAIL nack_done got %0d want 1", n_done); else n_pass++;
    nack_idx = -1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.ack_error !== 1'b1) $display("FAIL nack_sticky got %b want 1", bus.ack_error); else n_pass++;
    mon_epoch++;
    @(posedge clk); #1 bus.start_xfer = 1'b1; bus.xfer_data = 24'h5A00FF;
    @(posedge clk); #1 bus.start_xfer = 1'b0;
    n_checks++; if (bus.ack_error !== 1'b0) $display("FAIL nack_clear got %b want 0", bus.ack_error); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL nack_restart_busy got %b want 1", bus.busy); else n_pass++;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin ended = 1'b1; break; end
    end
    n_checks++; if (!ended) $display("FAIL nack_restart_timeout got timeout want done"); else n_pass++;
    n_checks++; if (n_done !== 1) $display("FAIL nack_restart_done got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_ignore_start();
    logic [23:0] d = 24'h9B_26_E1;
    logic [7:0]  exp;
    bit to;
    do_frame(d, 60, 24'hA5_5A_C3, to);
    n_checks++; if (to) $display("FAIL ign_timeout got timeout want done"); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp = d[23-8*i -: 8];
      n_checks++; if (rx[i] !== exp) $display("FAIL ign_byte%0d got %h want %h", i, rx[i], exp); else n_pass++;
    end
    n_checks++; if (n_done !== 1)  $display("FAIL ign_done got %0d want 1", n_done);   else n_pass++;
    n_checks++; if (n_start !== 1) $display("FAIL ign_start got %0d want 1", n_start); else n_pass++;
  endtask

  task automatic test_same_clk_strobes();
    logic [23:0] d = 24'h57_B0_3C;
    logic [7:0]  exp;
    bit to;
    inject_ml = 3;
    do_frame(d, -1, 24'h0, to);
    inject_ml = -1;
    n_checks++; if (to) $display("FAIL both_timeout got timeout want done"); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp = d[23-8*i -: 8];
      n_checks++; if (rx[i] !== exp) $display("FAIL both_byte%0d got %h want %h", i, rx[i], exp); else n_pass++;
    end
    n_checks++; if (n_done !== 1) $display("FAIL both_done got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_reset_mid_byte();
    bit found = 1'b0;
    mon_epoch++;
    @(negedge clk);
    @(posedge clk); #1 bus.start_xfer = 1'b1; bus.xfer_data = 24'hF0_F0_F0;
    @(posedge clk); #1 bus.start_xfer = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (n_rx == 1 && mon_bit == 4) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) $display("FAIL rst_mid_reach got timeout want byte2 bit4"); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL rst_mid_busy_before got %b want 1", bus.busy); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.i2c_sclk !== 1'b1)   $display("FAIL rst_mid_sclk got %b want 1", bus.i2c_sclk);     else n_pass++;
    n_checks++; if (bus.sdat_oe !== 1'b0)    $display("FAIL rst_mid_oe got %b want 0", bus.sdat_oe);        else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)       $display("FAIL rst_mid_busy got %b want 0", bus.busy);         else n_pass++;
    n_checks++; if (bus.clk_enable !== 1'b0) $display("FAIL rst_mid_clken got %b want 0", bus.clk_enable); else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    n_checks++; if (n_done !== 0)      $display("FAIL rst_mid_done got %0d want 0", n_done);    else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_restart got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] da = 24'h12_AB_80;
    logic [23:0] db = 24'hFE_01_6D;
    logic [7:0]  exp;
    bit got_done = 1'b0;
    bit ended    = 1'b0;
    int low_cnt  = 0;
    mon_epoch++;
    @(negedge clk);
    @(posedge clk); #1 bus.start_xfer = 1'b1; bus.xfer_data = da;
    @(posedge clk); #1 bus.start_xfer = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin got_done = 1'b1; break; end
    end
    n_checks++; if (!got_done) $display("FAIL b2b_first_timeout got timeout want done"); else n_pass++;
    @(posedge clk); #1 bus.start_xfer = 1'b1; bus.xfer_data = db;
    @(negedge clk); if (bus.clk_enable !== 1'b1) low_cnt++;
    @(posedge clk); #1 bus.start_xfer = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.clk_enable !== 1'b1) low_cnt++;
      if (bus.done === 1'b1) begin ended = 1'b1; break; end
    end
    @(negedge clk);
    n_checks++; if (!ended) $display("FAIL b2b_second_timeout got timeout want done"); else n_pass++;
    n_checks++; if (low_cnt !== 1) $display("FAIL b2b_clken_gap got %0d want 1", low_cnt); else n_pass++;
    n_checks++; if (n_done !== 2)  $display("FAIL b2b_done got %0d want 2", n_done);       else n_pass++;
    n_checks++; if (n_start !== 2) $display("FAIL b2b_start got %0d want 2", n_start);     else n_pass++;
    n_checks++; if (n_stop !== 2)  $display("FAIL b2b_stop got %0d want 2", n_stop);       else n_pass++;
    for (int i = 0; i < 6; i++) begin
      exp = (i < 3) ? da[23-8*i -: 8] : db[23-8*(i-3) -: 8];
      n_checks++; if (rx[i] !== exp) $display("FAIL b2b_byte%0d got %h want %h", i, rx[i], exp); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_nack();
    test_ignore_start();
    test_same_clk_strobes();
    test_reset_mid_byte();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
